// File: rtl/leaf_endpoint_rx_pkg.sv
// Shared constants for the leaf router receive endpoint.
// The ROUTER_WIDTH and LEAF_RX_DEPTH fallbacks below apply only when router.vh
// has not already defined them. LEAF_RX_DEPTH is the single source for the
// endpoint FIFO depth and for the router's per-port initial credit count.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif
`ifndef LEAF_RX_DEPTH
`define LEAF_RX_DEPTH 4
`endif

package leaf_endpoint_rx_pkg;
  localparam int ROUTER_WIDTH_P  = `ROUTER_WIDTH;
  localparam int LEAF_RX_DEPTH_P = `LEAF_RX_DEPTH;
endpackage

// File: rtl/leaf_endpoint_rx_credit_sync_fifo.sv
// Circular-buffer FIFO for the leaf receive endpoint: memory, pointers and count.
// A push is accepted when a slot is free, or when a pop frees one in the same
// cycle. A refused push leaves the pointers and the count unchanged.
module leaf_endpoint_rx_credit_sync_fifo
  import leaf_endpoint_rx_pkg::*;
#(
  parameter int DATA_W = ROUTER_WIDTH_P,
  parameter int DEPTH  = LEAF_RX_DEPTH_P
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push;

  assign push    = push_req_i && ((cnt_q != FULL_CNT) || pop_i);
  assign rdata_o = mem_q[rp_q];
  assign cnt_o   = cnt_q;

  // Next-state for the pointers and the count. Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop_i) rp_d = rp_q + 1'b1;
    if (push && !pop_i) cnt_d = cnt_q + 1'b1;
    else if (!push && pop_i) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array. It is not reset, because the head is only observed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/leaf_endpoint_rx.sv
// Leaf router receive endpoint: buffers flits pushed under credit flow control,
// hands them to the PE over valid/ready, and returns one credit per freed slot.
// The optional macro LEAF_RX_OVF_CHECK_EN enables a sticky overflow flag for
// pushes that arrive while the FIFO is full with no pop in the same cycle.
module leaf_endpoint_rx
  import leaf_endpoint_rx_pkg::*;
#(
  parameter int DATA_W = ROUTER_WIDTH_P,
  parameter int DEPTH  = LEAF_RX_DEPTH_P
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_data_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_credit,
  output logic                   pe_valid,
  output logic [DATA_W-1:0]      pe_data,
  input  logic                   pe_ready,
  output logic                   ovf_err,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);

  logic pop;
  logic credit_q;

  assign pe_valid   = (occupancy != '0);
  assign pop        = pe_valid && pe_ready;
  assign out_credit = credit_q;

  leaf_endpoint_rx_credit_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (in_data_valid),
    .pop_i      (pop),
    .wdata_i    (in_data),
    .rdata_o    (pe_data),
    .cnt_o      (occupancy)
  );

  // Each pop becomes exactly one credit pulse in the following cycle. A reset discards any pending credit.
  always_ff @(posedge clk) begin
    if (!rst) credit_q <= 1'b0;
    else      credit_q <= pop;
  end

`ifdef LEAF_RX_OVF_CHECK_EN
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic ovf_q;
  logic drop;

  assign drop    = in_data_valid && (occupancy == FULL_CNT) && !pop;
  assign ovf_err = ovf_q;

  // Sticky flag, set by the first push the router sends without holding a credit.
  always_ff @(posedge clk) begin
    if (!rst)      ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

`ifndef SYNTHESIS
  // Report each dropped flit while simulating.
  always_ff @(posedge clk) begin
    if (rst && drop) $error("leaf_endpoint_rx: flit dropped on full FIFO (credit protocol violation)");
  end
`endif
`else
  assign ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_leaf_endpoint_rx.sv
module tb_leaf_endpoint_rx;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef LEAF_RX_OVF_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_data_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_credit;
  logic              pe_valid;
  logic [DATA_W-1:0] pe_data;
  logic              pe_ready;
  logic              ovf_err;
  logic [2:0]        occupancy;

  int checks   = 0;
  int failures = 0;

  leaf_endpoint_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data_valid (in_data_valid),
    .in_data       (in_data),
    .out_credit    (out_credit),
    .pe_valid      (pe_valid),
    .pe_data       (pe_data),
    .pe_ready      (pe_ready),
    .ovf_err       (ovf_err),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] d);
    in_data_valid = 1'b1;
    in_data       = d;
    step();
    in_data_valid = 1'b0;
  endtask

  logic [31:0] mq[$];
  int          credits;
  int          got;
  int          sent;
  logic [31:0] r;

  initial begin
    rst = 1'b0; in_data_valid = 1'b0; in_data = '0; pe_ready = 1'b0;
    step(); step();
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_valid", 32'(pe_valid), 0);
    chk("rst_credit", 32'(out_credit), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    rst = 1'b1;
    step();

    // single flit
    push_one(32'hA5A5A5A5);
    chk("single_valid", 32'(pe_valid), 1);
    chk("single_data", pe_data, 32'hA5A5A5A5);
    chk("single_occ", 32'(occupancy), 1);
    chk("single_nocredit", 32'(out_credit), 0);
    pe_ready = 1'b1;
    step();
    chk("single_credit", 32'(out_credit), 1);
    chk("single_occ0", 32'(occupancy), 0);
    chk("single_empty", 32'(pe_valid), 0);
    pe_ready = 1'b0;
    step();
    chk("single_credit_once", 32'(out_credit), 0);

    // fill with the PE stalled
    for (int i = 1; i <= 4; i++) begin
      push_one(32'(i));
      chk("fill_nocredit", 32'(out_credit), 0);
    end
    chk("fill_occ", 32'(occupancy), 4);
    chk("fill_valid", 32'(pe_valid), 1);
    chk("fill_head", pe_data, 1);
    pe_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", pe_data, 32'(i));
      step();
      chk("drain_credit", 32'(out_credit), 1);
    end
    chk("drain_occ", 32'(occupancy), 0);
    step();
    chk("drain_credit_end", 32'(out_credit), 0);
    pe_ready = 1'b0;

    // full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push_one(32'(i));
    chk("fullpp_occ_pre", 32'(occupancy), 4);
    in_data_valid = 1'b1; in_data = 32'd5; pe_ready = 1'b1;
    step();
    in_data_valid = 1'b0; pe_ready = 1'b0;
    chk("fullpp_occ", 32'(occupancy), 4);
    chk("fullpp_ovf", 32'(ovf_err), 0);
    chk("fullpp_head", pe_data, 2);
    pe_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("fullpp_order", pe_data, 32'(i));
      step();
    end
    pe_ready = 1'b0;
    chk("fullpp_empty", 32'(occupancy), 0);

    // overflow: push into a full FIFO with no pop
    for (int i = 0; i < 4; i++) push_one(32'h11 + 32'(i));
    push_one(32'hDEAD);
    chk("ovf_occ", 32'(occupancy), 4);
    chk("ovf_flag", 32'(ovf_err), 32'(OVF_EXP));
    step();
    chk("ovf_sticky", 32'(ovf_err), 32'(OVF_EXP));
    pe_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", pe_data, 32'h11 + 32'(i));
      step();
    end
    pe_ready = 1'b0;
    chk("ovf_empty", 32'(occupancy), 0);
    chk("ovf_no_dead", 32'(pe_valid), 0);

    // streaming at full rate
    mq.delete();
    credits = 0; got = 0; sent = 0;
    pe_ready = 1'b1;
    step();
    for (int cyc = 0; cyc < 110; cyc++) begin
      chk("stream_valid", 32'(pe_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("stream_data", pe_data, mq[0]);
        void'(mq.pop_front());
        got++;
      end
      if (sent < 100) begin
        r = $urandom;
        in_data_valid = 1'b1;
        in_data = r;
        mq.push_back(r);
        sent++;
      end else begin
        in_data_valid = 1'b0;
      end
      step();
      if (out_credit === 1'b1) credits++;
      chk("stream_occ", 32'(occupancy), 32'(mq.size()));
    end
    in_data_valid = 1'b0;
    chk("stream_got", 32'(got), 100);
    chk("stream_credits", 32'(credits), 100);
    pe_ready = 1'b0;

    // reset in the middle of operation
    for (int i = 0; i < 4; i++) push_one(32'h30 + 32'(i));
    pe_ready = 1'b1;
    step();
    pe_ready = 1'b0;
    chk("mid_occ_pre", 32'(occupancy), 3);
    chk("mid_credit_pre", 32'(out_credit), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_occ", 32'(occupancy), 0);
    chk("mid_valid", 32'(pe_valid), 0);
    chk("mid_credit", 32'(out_credit), 0);
    chk("mid_ovf", 32'(ovf_err), 0);
    step();
    chk("mid_credit_after", 32'(out_credit), 0);
    push_one(32'h77);
    chk("post_rst_data", pe_data, 32'h77);
    chk("post_rst_occ", 32'(occupancy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/leaf_endpoint_rx.md
# leaf_endpoint_rx

Receive-side endpoint for one output direction of a leaf router in the broadcasting network. It accepts flits pushed by the router under credit-based flow control and buffers them in a local FIFO. It presents them to the processing element (PE) through a valid/ready handshake, and returns one credit pulse to the router for every buffer slot the PE frees. This is the consumer end of the router's `out_data_valid` / `out_data` / `out_credit` interface.

## Interface
- `DATA_W`, default `` `ROUTER_WIDTH ``: flit width in bits.
- `DEPTH`, default 4: FIFO entries. Must equal the router's per-port initial credit count. Power of two, ≥2.

- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low (low = reset)
- `in_data_valid`  in  1  flit valid from leaf router output port
- `in_data`  in  DATA_W  flit payload
- `out_credit`  out  1  one-cycle credit pulse to router; one pulse per freed slot
- `pe_valid`  out  1  FIFO head valid toward PE
- `pe_data`  out  DATA_W  FIFO head payload
- `pe_ready`  in  1  PE accepts head this cycle
- `ovf_err`  out  1  sticky overflow flag (see Configuration)
- `occupancy`  out  $clog2(DEPTH)+1  current entry count

## Operation
- **Storage:**
  - Circular buffer with write pointer `wp` and read pointer `rp`, both `$clog2(DEPTH)` bits, plus a count register `cnt`.
  - Pointers wrap modulo DEPTH with no special case.
- **Push:** when `in_data_valid`=1 and (`cnt`<DEPTH or pop this cycle), write `in_data` at `wp`, then `wp`++.
- **Pop:** when `pe_valid`&&`pe_ready`, `rp`++.
- **`pe_valid`:** equals (`cnt`!=0). `pe_data` = mem[`rp`], driven combinationally from registered state.
- **Count update:** `cnt` += push − pop, so a simultaneous push and pop leaves `cnt` unchanged.
- **Credit return:** `out_credit` is registered and equals the pop of the previous cycle. Credits are neither coalesced nor dropped: exactly one pulse per pop.
- **Empty:** `pe_valid`=0 and `pe_ready` is ignored. No pop and no credit result.
- **Full with simultaneous pop:** the push is accepted and no overflow is flagged.
- **Full without pop plus incoming valid:** this is a protocol violation by the router.
  - The flit is dropped.
  - Pointers and `cnt` are unchanged.
  - `ovf_err` is handled per Configuration.
- **Reset state** (applied at any clock edge while `rst`=0, including mid-transfer):
  - `wp`=`rp`=`cnt`=0.
  - `out_credit`=0, `pe_valid`=0, `occupancy`=0, `ovf_err`=0.
  - Memory contents are not reset. `pe_data` is don't-care while `pe_valid`=0.
  - Credits pending at reset are discarded. The router resets in the same cycle and restores DEPTH credits itself.

## Timing
- Flit present on `in_data_valid` at cycle N: `pe_valid`=1 and `pe_data` valid in cycle N+1. No combinational in→out bypass.
- Pop at cycle M: `out_credit`=1 in cycle M+1 only.
- Back-to-back pops produce back-to-back credit pulses.
- Full-throughput steady state: one flit in, one flit out and one credit out per cycle. No bubbles once the FIFO is non-empty.
- Round-trip: slot freed at M, credit visible to router at M+1, earliest reuse push at M+2. DEPTH≥2 sustains throughput provided the router's credit loop is ≤2 cycles.

## Configuration
- `LEAF_RX_OVF_CHECK_EN` defined:
  - `ovf_err` is a register, set on the first dropped push.
  - It holds until reset.
  - Under simulation, a `$error` reports the drop.
- Not defined:
  - `ovf_err` is tied to 0 and no checking logic is synthesized.
  - A dropped push is still silently discarded, with pointers unchanged.

## Structure
- Shared constants come from `router.vh`: `` `ROUTER_WIDTH ``, `` `DIRECTION ``. Add `` `LEAF_RX_DEPTH `` there as the single source for DEPTH and the router credit init.
- The natural sub-module is `credit_sync_fifo`, which holds the memory, pointers and count.
- The top level adds credit registration, overflow logic and the PE handshake.

## Test plan
- **Single flit:** reset, then in_data_valid=1, in_data=0xA5A5A5A5 at cycle 5 → `pe_valid`=1, `pe_data`=0xA5A5A5A5 at cycle 6. Pop at cycle 6 → `out_credit`=1 at cycle 7 only, occupancy back to 0.
- **Fill with PE stalled:** `pe_ready`=0, push 4 flits 1..4 → occupancy=4, `pe_valid`=1, head=1, no credits. Then `pe_ready`=1 for 4 cycles → data 1,2,3,4 in order and exactly 4 consecutive credit pulses.
- **Full with simultaneous push and pop:** occupancy=4, push 5 while popping 1 → occupancy stays 4, `ovf_err`=0, later order 2,3,4,5.
- **Overflow (macro defined):** occupancy=4, `pe_ready`=0, push 0xDEAD → `ovf_err`=1 next cycle and sticky, 0xDEAD never appears, occupancy=4. Without the macro, `ovf_err` stays 0.
- **Streaming:** 100 random flits at full rate with `pe_ready`=1 → in-order delivery, credits total 100, wrap-around exercised 25×.
- **Mid-operation reset:** occupancy=3 and a credit pending, assert `rst`=0 for one cycle → next cycle occupancy=0, `pe_valid`=0, `out_credit`=0, `ovf_err`=0.
